// File: rtl/asteroids_pkg.sv
// Shared types and constants for the Asteroids NVRAM upload path.
package asteroids_pkg;

   // Uploader FSM states
   typedef enum logic [2:0] {
      IDLE,
      PAUSE_WAIT,
      PREFETCH,
      SERVE,
      DONE
   } nvup_state_t;

   // ioctl_index used by the host for the high-score/EAROM image
   localparam logic [7:0] NVRAM_IDX = 8'd4;

   // Default number of NVRAM bytes in the image
   localparam int unsigned NV_SIZE_DEFAULT = 64;

   // True when a byte address lies inside the NVRAM image (wide compare, no wrap)
   function automatic logic addr_in_image(input logic [25:0] addr, input int unsigned size);
      return addr < 26'(size);
   endfunction

endpackage

// File: rtl/hiscore_nvram_uploader_req_timer.sv
// Loadable down-counter holding the upload request to the host.
// The request stays high while the count is non-zero, so a load of N
// keeps it high for exactly N clocks unless the host answers first.
module req_timer #(
   parameter int unsigned LOAD_VAL = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_clear,
   output logic o_req,
   output logic o_zero
);

   localparam int unsigned CNT_W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

   logic [CNT_W-1:0] r_count;

   // Clear wins over load; otherwise count down to zero and stop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= CNT_W'(LOAD_VAL);
      end else if (r_count != '0) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);
   assign o_req  = ~o_zero;

endmodule

// File: rtl/hiscore_nvram_uploader.sv
// Serves the high-score NVRAM image to the host over the hps_io upload path.
// A save request asks the host to start an upload; once it does, the CPU is
// paused and each host read strobe returns the next image byte two clocks later.
module hiscore_nvram_uploader
   import asteroids_pkg::*;
#(
   parameter int unsigned NV_SIZE      = NV_SIZE_DEFAULT,
   parameter int unsigned ADDR_W       = 6,
   parameter logic [7:0]  UPLOAD_INDEX = NVRAM_IDX,
   parameter int unsigned REQ_TIMEOUT  = 65535
) (
   input  logic              clk_25,
   input  logic              reset,
   input  logic              save_req,
   input  logic              ioctl_upload,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_upload_req,
   output logic              cpu_pause,
   input  logic              pause_ack,
   output logic [ADDR_W-1:0] nv_addr,
   output logic              nv_rd,
   input  logic [7:0]        nv_q,
   output logic              busy
);

   nvup_state_t r_state;
   nvup_state_t w_state_next;

   logic        r_save_q;
   logic [7:0]  r_din;
   logic        r_lat_nv;      // ioctl_din takes nv_q at the next edge
   logic        r_lat_ff;      // ioctl_din takes 8'hFF at the next edge
   logic        r_pend_v;      // a strobe arrived during an update and waits
   logic [24:0] r_pend_addr;

   logic [7:0]  w_din_next;
   logic        w_lat_nv_next;
   logic        w_lat_ff_next;
   logic        w_pend_v_next;
   logic [24:0] w_pend_addr_next;
   logic        w_issue;
   logic [24:0] w_src_addr;
   logic [25:0] w_next;
   logic        w_nv_rd;
   logic [ADDR_W-1:0] w_nv_addr;
   logic        w_cpu_pause;
   logic        w_busy;

   logic        w_hit;
   logic        w_save_rise;
   logic        w_req_zero;
   logic        w_req;
   logic        w_load;

   assign w_hit       = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
   assign w_save_rise = save_req && !r_save_q;
   // New requests only start from an idle block with nothing outstanding
   assign w_load      = w_save_rise && (r_state == IDLE) && w_req_zero;

   req_timer #(
      .LOAD_VAL (REQ_TIMEOUT)
   ) u_req_timer (
      .clk     (clk_25),
      .rst     (reset),
      .i_load  (w_load),
      .i_clear (w_hit),
      .o_req   (w_req),
      .o_zero  (w_req_zero)
   );

   // State register
   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state, NVRAM read port and the read-strobe queue
   always_comb begin
      w_state_next     = r_state;
      w_din_next       = r_din;
      w_lat_nv_next    = 1'b0;
      w_lat_ff_next    = 1'b0;
      w_pend_v_next    = r_pend_v;
      w_pend_addr_next = r_pend_addr;
      w_issue          = 1'b0;
      w_src_addr       = '0;
      w_next           = '0;
      w_nv_rd          = 1'b0;
      w_nv_addr        = '0;
      w_cpu_pause      = 1'b0;
      w_busy           = 1'b0;

      case (r_state)
         IDLE: begin
            w_pend_v_next = 1'b0;
            if (w_hit) begin
               w_state_next = PAUSE_WAIT;
            end
         end

         PAUSE_WAIT: begin
            w_cpu_pause = 1'b1;
            w_busy      = 1'b1;
            if (!ioctl_upload) begin
               w_state_next = DONE;
               w_din_next   = 8'h00;
            end else if (pause_ack) begin
               w_state_next = PREFETCH;
            end
         end

         PREFETCH: begin
            w_cpu_pause = 1'b1;
            w_busy      = 1'b1;
            if (!ioctl_upload) begin
               w_state_next  = DONE;
               w_din_next    = 8'h00;
               w_pend_v_next = 1'b0;
            end else begin
               // Byte 0 is ready on ioctl_din before the host's first strobe
               w_nv_rd       = 1'b1;
               w_lat_nv_next = 1'b1;
               w_state_next  = SERVE;
               if (ioctl_rd) begin
                  w_pend_v_next    = 1'b1;
                  w_pend_addr_next = ioctl_addr;
               end
            end
         end

         SERVE: begin
            w_cpu_pause = 1'b1;
            w_busy      = 1'b1;
            if (!ioctl_upload) begin
               // Upload end beats any strobe in the same clock
               w_state_next  = DONE;
               w_din_next    = 8'h00;
               w_pend_v_next = 1'b0;
            end else begin
               if (r_lat_nv) begin
                  w_din_next = nv_q;
               end else if (r_lat_ff) begin
                  w_din_next = 8'hFF;
               end
               // A queued strobe goes before a fresh one
               if (!(r_lat_nv || r_lat_ff)) begin
                  if (r_pend_v) begin
                     w_issue       = 1'b1;
                     w_src_addr    = r_pend_addr;
                     w_pend_v_next = 1'b0;
                  end else if (ioctl_rd) begin
                     w_issue    = 1'b1;
                     w_src_addr = ioctl_addr;
                  end
               end
               // Strobes that cannot start now wait; a later one overwrites
               if (ioctl_rd && (r_lat_nv || r_lat_ff || r_pend_v)) begin
                  w_pend_v_next    = 1'b1;
                  w_pend_addr_next = ioctl_addr;
               end
               if (w_issue) begin
                  // Host reads address A, and the byte for A+1 is fetched
                  w_next = {1'b0, w_src_addr} + 26'd1;
                  if (addr_in_image(w_next, NV_SIZE)) begin
                     w_nv_rd       = 1'b1;
                     w_nv_addr     = w_next[ADDR_W-1:0];
                     w_lat_nv_next = 1'b1;
                  end else begin
                     w_lat_ff_next = 1'b1;
                  end
               end
            end
         end

         DONE: begin
            w_busy        = 1'b1;
            w_din_next    = 8'h00;
            w_pend_v_next = 1'b0;
            w_state_next  = IDLE;
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Data-side registers: save edge detector, output byte and read queue
   always_ff @(posedge clk_25 or posedge reset) begin
      if (reset) begin
         r_save_q    <= 1'b0;
         r_din       <= 8'h00;
         r_lat_nv    <= 1'b0;
         r_lat_ff    <= 1'b0;
         r_pend_v    <= 1'b0;
         r_pend_addr <= '0;
      end else begin
         r_save_q    <= save_req;
         r_din       <= w_din_next;
         r_lat_nv    <= w_lat_nv_next;
         r_lat_ff    <= w_lat_ff_next;
         r_pend_v    <= w_pend_v_next;
         r_pend_addr <= w_pend_addr_next;
      end
   end

   assign ioctl_din        = r_din;
   assign ioctl_upload_req = w_req;
   assign cpu_pause        = w_cpu_pause;
   assign nv_rd            = w_nv_rd;
   assign nv_addr          = w_nv_addr;
   assign busy             = w_busy;

endmodule
